image_write_packer: RTL and testbench
=====================================

Name: image_write_packer

Overview:
- Sits directly downstream of the image buffer writer. Consumes its 54-bit pixel-word stream {mask[3:0], frame, addr[16:0], data[31:0]} over valid/ready.
- Packs four consecutive 32-bit words into one 128-bit DRAM write beat. Computes the byte address from the frame double-buffer base and emits one combined command+data transaction to the memory arbiter.
- Flushes partial beats, with unused words disabled, on discontinuity or on request. Pulses frame_done when the last beat of a frame is accepted.

Parameters:
- N_PIXEL, 480000, pixels per frame; MAX_ADDR = N_PIXEL/4 - 1 word index.
- FRAME0_BASE, 31'h0100_0000, byte base address of frame buffer 0.
- FRAME1_BASE, 31'h0140_0000, byte base address of frame buffer 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  54  {mask[3:0] byte enables, frame, addr[16:0] word index, data[31:0]}.
- din_valid  in  1  din valid.
- din_ready  out  1  word accepted when din_valid & din_ready.
- flush  in  1  level; emit the held partial beat.
- mem_addr  out  31  beat byte address, 16-byte aligned.
- mem_wdata  out  128  word k at bits [32k+31:32k].
- mem_wbe  out  16  byte enables, active-high; bits [4k+3:4k] for word k.
- mem_valid  out  1  transaction valid.
- mem_ready  in  1  transaction accepted when mem_valid & mem_ready.
- frame_done  out  1  one-cycle pulse.
- frame_id  out  1  frame bit of the beat that completed the frame.

Behaviour:
- Reset: state EMPTY; din_ready=0 during reset; mem_valid=0, mem_wbe=0, mem_wdata=0, mem_addr=0, frame_done=0, frame_id=0. Reset mid-beat discards held words; no partial write is issued.
- Beat key = {frame, addr[16:2]}. Lane = addr[1:0].
- mem_addr = (frame ? FRAME1_BASE : FRAME0_BASE) + {addr[16:2], 4'b0}. Compute at 31 bits, no carry out.
- States:
  - EMPTY: din_ready=1. An accepted word stores key, writes its lane data, sets its 4 wbe bits from mask, goes to FILL. If its lane is 3, go to FULL instead.
  - FILL: din_ready=1 only if the incoming key equals the held key, or din_valid=0.
    - Same key: write the lane. A repeated lane overwrites both data and wbe. Lane 3 goes to FULL.
    - Different key: do not accept; go to FULL. The word is accepted after the beat drains.
    - flush=1 with no word accepted this cycle goes to FULL.
  - FULL: mem_valid=1, din_ready=0; outputs held stable until mem_ready.
    - On handshake, clear wbe and data, go to EMPTY.
    - Bypass: a word arriving in the same cycle is not accepted. Fixed one-cycle bubble per beat.
- Latency: the lane-3 word accepted at cycle N gives mem_valid=1 at N+1. Peak throughput is 4 words per 5 cycles.
- Lanes never written in a beat have wbe=0 and data=0.
- frame_done: pulses in the cycle after the handshake of a beat whose held key has addr[16:2] == MAX_ADDR>>2. frame_id is the frame bit of that beat and holds until the next pulse. A partial last beat counts.
- flush in EMPTY or FULL: no effect.
- addr > MAX_ADDR: packed normally, and never produces frame_done.

Decomposition:
- Shared package (image_pkg): widths PIX_ADDR_W=17, WORD_W=32, BEAT_W=128, MEM_ADDR_W=31; din field offsets; state encoding EMPTY/FILL/FULL.
- Sub-module: beat_assembler, holding the 128-bit data register, 16-bit wbe register, key register and lane write/clear logic. The FSM and address/frame_done logic stay in the top.

Test Plan:
- Contiguous stream, frame=0, addr 0..7, data=addr, mask=F, mem_ready=1 → two beats:
  - addr 31'h0100_0000, wdata 128'h3_00000002_00000001_00000000 (words 3..0), wbe FFFF;
  - addr 31'h0100_0010, words 7..4.
- Backpressure: mem_ready=0 for 10 cycles on the first beat → mem_* stable, din_ready=0. Release → one handshake, then addr 4 accepted.
- Discontinuity: frame=1, addrs 0, 1, then 8 → beat at 31'h0140_0000 with wbe 00FF. Then addr 8 is held at lane 0, key {1, 2}.
- Flush: addrs 4, 6, then flush=1 with din_valid=0 → beat at 31'h0100_0010 with wbe 0F0F, words 1 and 3 zero.
- End of frame: N_PIXEL=64 (MAX_ADDR=15), frame=1, addrs 12..15 → beat at 31'h0140_0030. frame_done pulses one cycle after the handshake; frame_id=1.
- Async reset asserted in FILL holding 3 words → mem_valid=0 immediately, no beat ever emitted. After release, addr 0 starts a fresh beat.

Source files
------------

// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared widths, din field offsets and FSM encoding for the image write packer
package image_pkg;

    localparam int PIX_ADDR_W = 17;
    localparam int WORD_W     = 32;
    localparam int BEAT_W     = 128;
    localparam int MEM_ADDR_W = 31;
    localparam int MASK_W     = 4;
    localparam int WBE_W      = 16;
    localparam int BEAT_IDX_W = PIX_ADDR_W - 2;
    localparam int KEY_W      = BEAT_IDX_W + 1;
    localparam int DIN_W      = 54;

    // din = {mask[3:0], frame, addr[16:0], data[31:0]}
    localparam int DATA_LSB  = 0;
    localparam int ADDR_LSB  = 32;
    localparam int FRAME_BIT = 49;
    localparam int MASK_LSB  = 50;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/beat_assembler.sv
// rtl/beat_assembler.sv - 128-bit beat data/byte-enable/key registers with lane write and clear
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_load        write i_data/i_mask into lane i_lane
//   i_start       with i_load: first word of a beat, capture i_key
//   i_clear       zero data and byte enables after the beat is taken
//   i_key         {frame, addr[16:2]} of the incoming word
//   i_lane        addr[1:0] of the incoming word
//   i_data        32-bit word
//   i_mask        4 byte enables for the word
//   o_key         held beat key
//   o_data        held beat data, lane k at [32k+31:32k]
//   o_wbe         held byte enables, lane k at [4k+3:4k]
module beat_assembler
    import image_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [KEY_W-1:0]  i_key,
    input  logic [1:0]        i_lane,
    input  logic [WORD_W-1:0] i_data,
    input  logic [MASK_W-1:0] i_mask,
    output logic [KEY_W-1:0]  o_key,
    output logic [BEAT_W-1:0] o_data,
    output logic [WBE_W-1:0]  o_wbe
);

    logic [KEY_W-1:0]  r_key;
    logic [BEAT_W-1:0] r_data;
    logic [WBE_W-1:0]  r_wbe;

    // Lanes are zeroed on clear so that lanes never written in the next beat
    // go out with data=0 and wbe=0; a repeated lane simply overwrites.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key  <= '0;
            r_data <= '0;
            r_wbe  <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_wbe  <= '0;
        end else if (i_load) begin
            if (i_start) begin
                r_key <= i_key;
            end
            r_data[{i_lane, 5'b0} +: WORD_W] <= i_data;
            r_wbe[{i_lane, 2'b0} +: MASK_W]  <= i_mask;
        end
    end

    assign o_key  = r_key;
    assign o_data = r_data;
    assign o_wbe  = r_wbe;

endmodule

// File: rtl/image_write_packer.sv
// rtl/image_write_packer.sv - packs four 32-bit pixel words into one 128-bit DRAM write beat
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   din, din_valid       {mask[3:0], frame, addr[16:0], data[31:0]} word stream
//   din_ready            word accepted when din_valid & din_ready
//   flush                level; pushes out a held partial beat
//   mem_addr             16-byte aligned beat byte address
//   mem_wdata, mem_wbe   beat data and active-high byte enables
//   mem_valid, mem_ready beat handshake to the memory arbiter
//   frame_done           one-cycle pulse after the last beat of a frame is taken
//   frame_id             frame bit of the beat that completed the frame
module image_write_packer
    import image_pkg::*;
#(
    parameter int                    N_PIXEL     = 480000,
    parameter logic [MEM_ADDR_W-1:0] FRAME0_BASE = 31'h0100_0000,
    parameter logic [MEM_ADDR_W-1:0] FRAME1_BASE = 31'h0140_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIN_W-1:0]      din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  flush,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0]     mem_wdata,
    output logic [WBE_W-1:0]      mem_wbe,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  frame_done,
    output logic                  frame_id
);

    localparam int MAX_ADDR = N_PIXEL / 4 - 1;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(MAX_ADDR >> 2);

    state_t r_state;
    state_t w_state_next;
    logic   r_frame_done;
    logic   r_frame_id;

    logic [WORD_W-1:0]     w_din_data;
    logic [PIX_ADDR_W-1:0] w_din_addr;
    logic                  w_din_frame;
    logic [MASK_W-1:0]     w_din_mask;
    logic [KEY_W-1:0]      w_din_key;
    logic [1:0]            w_din_lane;
    logic [KEY_W-1:0]      w_held_key;
    logic                  w_same_key;
    logic                  w_ready;
    logic                  w_load;
    logic                  w_start;
    logic                  w_clear;
    logic                  w_mem_valid;
    logic                  w_handshake;
    logic [MEM_ADDR_W-1:0] w_base;
    logic                  w_last_beat;

    assign w_din_data  = din[DATA_LSB +: WORD_W];
    assign w_din_addr  = din[ADDR_LSB +: PIX_ADDR_W];
    assign w_din_frame = din[FRAME_BIT];
    assign w_din_mask  = din[MASK_LSB +: MASK_W];
    assign w_din_key   = {w_din_frame, w_din_addr[PIX_ADDR_W-1:2]};
    assign w_din_lane  = w_din_addr[1:0];
    assign w_same_key  = (w_din_key == w_held_key);

    beat_assembler u_beat (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_load  (w_load),
        .i_start (w_start),
        .i_clear (w_clear),
        .i_key   (w_din_key),
        .i_lane  (w_din_lane),
        .i_data  (w_din_data),
        .i_mask  (w_din_mask),
        .o_key   (w_held_key),
        .o_data  (mem_wdata),
        .o_wbe   (mem_wbe)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A word for a different beat is refused in FILL; the held beat goes out
    // first and the word is taken from EMPTY after the one-cycle bubble.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_load       = 1'b0;
        w_start      = 1'b0;
        w_clear      = 1'b0;
        w_mem_valid  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_ready = 1'b1;
                if (din_valid) begin
                    w_load       = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = (w_din_lane == 2'd3) ? ST_FULL : ST_FILL;
                end
            end
            ST_FILL: begin
                w_ready = !din_valid || w_same_key;
                if (din_valid) begin
                    if (w_same_key) begin
                        w_load = 1'b1;
                        if (w_din_lane == 2'd3) begin
                            w_state_next = ST_FULL;
                        end
                    end else begin
                        w_state_next = ST_FULL;
                    end
                end else if (flush) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                w_mem_valid = 1'b1;
                if (mem_ready) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_EMPTY;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    assign din_ready   = w_ready & ~reset;
    assign mem_valid   = w_mem_valid;
    assign w_handshake = w_mem_valid & mem_ready;

    assign w_base   = w_held_key[KEY_W-1] ? FRAME1_BASE : FRAME0_BASE;
    assign mem_addr = w_mem_valid
                    ? w_base + {{(MEM_ADDR_W - BEAT_IDX_W - 4){1'b0}}, w_held_key[BEAT_IDX_W-1:0], 4'b0}
                    : '0;

    assign w_last_beat = (w_held_key[BEAT_IDX_W-1:0] == LAST_BEAT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
            r_frame_id   <= 1'b0;
        end else begin
            r_frame_done <= w_handshake && w_last_beat;
            if (w_handshake && w_last_beat) begin
                r_frame_id <= w_held_key[KEY_W-1];
            end
        end
    end

    assign frame_done = r_frame_done;
    assign frame_id   = r_frame_id;

endmodule

// File: tb/tb_image_write_packer.sv
// tb/tb_image_write_packer.sv - self-checking bench for image_write_packer
module tb_image_write_packer;

    localparam int TB_N_PIXEL  = 64;
    localparam int TB_MAX_ADDR = TB_N_PIXEL / 4 - 1;

    typedef struct {
        logic [30:0]  addr;
        logic [127:0] data;
        logic [15:0]  wbe;
        int           cyc;
    } beat_t;

    typedef struct {
        logic id;
        int   cyc;
    } fd_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [53:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic         flush;
    logic [30:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wbe;
    logic         mem_valid;
    logic         mem_ready;
    logic         frame_done;
    logic         frame_id;

    image_write_packer #(.N_PIXEL(TB_N_PIXEL)) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wbe    (mem_wbe),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .frame_done (frame_done),
        .frame_id   (frame_id)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    beat_t got_q[$];
    fd_t   fd_q[$];
    beat_t exp_q[$];
    logic  exp_fd[$];

    // reference model state: the beat currently being gathered
    bit           m_valid = 0;
    logic         m_frame;
    int           m_beat;
    logic [127:0] m_data;
    logic [15:0]  m_wbe;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_valid && mem_ready) got_q.push_back('{mem_addr, mem_wdata, mem_wbe, cyc});
        if (frame_done) fd_q.push_back('{frame_id, cyc});
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_close();
        beat_t b;
        b.addr = (m_frame ? 31'h0140_0000 : 31'h0100_0000) + 31'(m_beat * 16);
        b.data = m_data;
        b.wbe  = m_wbe;
        b.cyc  = 0;
        exp_q.push_back(b);
        if (m_beat == TB_MAX_ADDR / 4 && m_beat * 4 <= TB_MAX_ADDR) exp_fd.push_back(m_frame);
        m_valid = 0;
    endtask

    task automatic model_word(input logic f, input int a, input logic [3:0] m, input logic [31:0] d);
        int beat = a / 4;
        int lane = a % 4;
        if (m_valid && (f != m_frame || beat != m_beat)) model_close();
        if (!m_valid) begin
            m_valid = 1;
            m_frame = f;
            m_beat  = beat;
            m_data  = '0;
            m_wbe   = '0;
        end
        m_data[lane*32 +: 32] = d;
        m_wbe[lane*4 +: 4]    = m;
        if (lane == 3) model_close();
    endtask

    task automatic model_flush();
        if (m_valid) model_close();
    endtask

    task automatic send_word(input logic f, input int a, input logic [3:0] m, input logic [31:0] d, input bit rnd);
        int n  = 0;
        bit ok = 0;
        din       = {m, f, 17'(a), d};
        din_valid = 1'b1;
        while (!ok && n < 200) begin
            if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (din_ready) ok = 1;
            @(posedge clock); #1;
            n++;
        end
        din_valid = 1'b0;
        chk($sformatf("send_accepted_a%0d", a), 128'(ok), 128'(1));
        if (ok) model_word(f, a, m, d);
    endtask

    task automatic flush_cycle(input bit rnd);
        flush     = 1'b1;
        din_valid = 1'b0;
        if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
        @(posedge clock); #1;
        flush = 1'b0;
        model_flush();
    endtask

    task automatic drain(input int n);
        din_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic lit(input string tag, input int idx, input logic [30:0] a, input logic [15:0] wbe);
        if (idx < got_q.size()) begin
            chk({tag, "_addr"}, 128'(got_q[idx].addr), 128'(a));
            chk({tag, "_wbe"}, 128'(got_q[idx].wbe), 128'(wbe));
        end else begin
            chk({tag, "_present"}, 128'(got_q.size()), 128'(idx + 1));
        end
    endtask

    task automatic compare_all(input string tag);
        int nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        int nf = (fd_q.size() < exp_fd.size()) ? fd_q.size() : exp_fd.size();
        chk({tag, "_nbeats"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 128'(got_q[i].addr), 128'(exp_q[i].addr));
            chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            chk($sformatf("%s_wbe%0d", tag, i), 128'(got_q[i].wbe), 128'(exp_q[i].wbe));
        end
        chk({tag, "_nframedone"}, 128'(fd_q.size()), 128'(exp_fd.size()));
        for (int i = 0; i < nf; i++) begin
            chk($sformatf("%s_frameid%0d", tag, i), 128'(fd_q[i].id), 128'(exp_fd[i]));
        end
        got_q.delete();
        exp_q.delete();
        fd_q.delete();
        exp_fd.delete();
    endtask

    initial begin
        int  n;
        bit  acc;
        logic f;
        int  beat;

        // reset state
        reset     = 1'b1;
        din       = {4'hF, 1'b0, 17'd3, 32'h0};
        din_valid = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_din_ready", 128'(din_ready), 128'(0));
        chk("rst_mem_valid", 128'(mem_valid), 128'(0));
        chk("rst_mem_wbe", 128'(mem_wbe), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        chk("rst_frame_id", 128'(frame_id), 128'(0));
        @(posedge clock); #1;
        reset     = 1'b0;
        din_valid = 1'b0;
        mem_ready = 1'b1;

        // contiguous stream, two full beats
        for (int a = 0; a < 8; a++) send_word(1'b0, a, 4'hF, 32'(a), 0);
        drain(3);
        lit("contig0", 0, 31'h0100_0000, 16'hFFFF);
        lit("contig1", 1, 31'h0100_0010, 16'hFFFF);
        if (got_q.size() > 0)
            chk("contig0_wdata_lit", got_q[0].data, 128'h00000003_00000002_00000001_00000000);
        compare_all("contig");

        // backpressure on the first beat
        mem_ready = 1'b0;
        for (int a = 0; a < 4; a++) send_word(1'b0, a, 4'hF, 32'h100 + 32'(a), 0);
        din       = {4'hF, 1'b0, 17'd4, 32'h104};
        din_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk($sformatf("bp_mem_valid%0d", k), 128'(mem_valid), 128'(1));
            chk($sformatf("bp_din_ready%0d", k), 128'(din_ready), 128'(0));
            chk($sformatf("bp_addr%0d", k), 128'(mem_addr), 128'(exp_q[0].addr));
            chk($sformatf("bp_wdata%0d", k), mem_wdata, exp_q[0].data);
            chk($sformatf("bp_wbe%0d", k), 128'(mem_wbe), 128'(exp_q[0].wbe));
            @(posedge clock); #1;
        end
        chk("bp_no_beat_while_stalled", 128'(got_q.size()), 128'(0));
        mem_ready = 1'b1;
        n   = 0;
        acc = 0;
        while (!acc && n < 10) begin
            @(negedge clock);
            n++;
            if (din_ready) acc = 1;
            @(posedge clock); #1;
        end
        din_valid = 1'b0;
        chk("bp_accept_delay", 128'(n), 128'(2));
        chk("bp_one_handshake", 128'(got_q.size()), 128'(1));
        if (acc) model_word(1'b0, 4, 4'hF, 32'h104);
        for (int a = 5; a < 8; a++) send_word(1'b0, a, 4'hF, 32'h100 + 32'(a), 0);
        drain(3);
        compare_all("bp");

        // discontinuity, then the held word is flushed out on its own
        send_word(1'b1, 0, 4'hF, 32'hA0, 0);
        send_word(1'b1, 1, 4'hF, 32'hA1, 0);
        send_word(1'b1, 8, 4'hF, 32'hA8, 0);
        drain(3);
        lit("disc", 0, 31'h0140_0000, 16'h00FF);
        compare_all("disc");
        flush_cycle(0);
        drain(3);
        lit("disc_held", 0, 31'h0140_0020, 16'h000F);
        compare_all("disc_held");

        // flush of a sparse beat; flush kept high through FULL and EMPTY
        send_word(1'b0, 4, 4'hF, 32'hC4, 0);
        send_word(1'b0, 6, 4'hF, 32'hC6, 0);
        flush = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        flush = 1'b0;
        model_flush();
        drain(3);
        lit("flush", 0, 31'h0100_0010, 16'h0F0F);
        if (got_q.size() > 0) begin
            chk("flush_word1_zero", 128'(got_q[0].data[63:32]), 128'(0));
            chk("flush_word3_zero", 128'(got_q[0].data[127:96]), 128'(0));
        end
        compare_all("flush");

        // end of frame
        for (int a = 12; a < 16; a++) send_word(1'b1, a, 4'hF, $urandom, 0);
        drain(4);
        lit("eof", 0, 31'h0140_0030, 16'hFFFF);
        if (got_q.size() > 0 && fd_q.size() > 0)
            chk("eof_fd_cycle", 128'(fd_q[0].cyc), 128'(got_q[0].cyc + 1));
        @(negedge clock);
        chk("eof_frame_id_held", 128'(frame_id), 128'(1));
        chk("eof_frame_done_low", 128'(frame_done), 128'(0));
        compare_all("eof");

        // partial last beat counts; beyond MAX_ADDR never does
        send_word(1'b0, 13, 4'h3, $urandom, 0);
        flush_cycle(0);
        drain(3);
        compare_all("eof_partial");
        for (int a = 16; a < 20; a++) send_word(1'b0, a, 4'hF, $urandom, 0);
        drain(3);
        compare_all("beyond_max");

        // asynchronous reset while holding three words
        for (int a = 0; a < 3; a++) send_word(1'b0, a, 4'hF, 32'hE0 + 32'(a), 0);
        din       = {4'hF, 1'b0, 17'd3, 32'hE3};
        din_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("amid_mem_valid", 128'(mem_valid), 128'(0));
        chk("amid_din_ready", 128'(din_ready), 128'(0));
        chk("amid_wbe_cleared", 128'(mem_wbe), 128'(0));
        repeat (2) begin
            @(posedge clock); #1;
        end
        din_valid = 1'b0;
        reset     = 1'b0;
        m_valid   = 0;
        drain(3);
        compare_all("amid");
        send_word(1'b0, 0, 4'h3, 32'h1234, 0);
        flush_cycle(0);
        drain(3);
        lit("amid_fresh", 0, 31'h0100_0000, 16'h0003);
        compare_all("amid_fresh");

        // flush in EMPTY does nothing
        flush = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        flush = 1'b0;
        drain(2);
        compare_all("flush_empty");

        // randomized stream with random stalls and flushes
        f    = 1'b0;
        beat = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                f    = 1'($urandom_range(0, 1));
                beat = $urandom_range(0, 7);
            end
            send_word(f, beat * 4 + $urandom_range(0, 3), 4'($urandom_range(0, 15)), $urandom, 1);
            if ($urandom_range(0, 15) == 0) flush_cycle(1);
        end
        flush_cycle(1);
        drain(20);
        compare_all("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
